// File: rtl/modulo_mostrar_numero_if.sv
// Bus between the calculator control logic and the 7-segment display driver.
interface modulo_mostrar_numero_if;
  logic [15:0] numero;
  logic        cargar;
  logic        error_en;
  logic [6:0]  segmentos;
  logic [3:0]  anodos;
  logic        listo;
  logic        invalido;

  modport master (
    output numero, cargar, error_en,
    input  segmentos, anodos, listo, invalido
  );

  modport slave (
    input  numero, cargar, error_en,
    output segmentos, anodos, listo, invalido
  );
endinterface

// File: rtl/modulo_mostrar_numero.sv
// Latches a 4-digit BCD value (or an error request) and drives a multiplexed,
// leading-zero-blanked 4-digit 7-segment display, showing "Err" on bad input.
module modulo_mostrar_numero #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input logic                     clk,
  input logic                     reset,
  modulo_mostrar_numero_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]       SEG_OFF = 7'h7F;
  localparam logic [3:0]       AN_OFF  = 4'hF;

  typedef enum logic [1:0] {
    APAGADO = 2'd0,
    BARRER  = 2'd1,
    ERROR   = 2'd2
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      valor_q, valor_d;
  logic             listo_q, listo_d;
  logic             inv_q, inv_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic             valido_c;
  logic [3:0]       nib_c;
  logic             blank_c;

  // BCD digit to active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Input value is valid only if every nibble is a BCD digit
  always_comb begin
    valido_c = (bus.numero[3:0]   <= 4'd9) && (bus.numero[7:4]   <= 4'd9) &&
               (bus.numero[11:8]  <= 4'd9) && (bus.numero[15:12] <= 4'd9);
  end

  // Next state, latch, scan counters and registered display values
  always_comb begin
    estado_d = estado_q;
    valor_d  = valor_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    listo_d  = bus.cargar | bus.error_en;
    seg_d    = SEG_OFF;
    an_d     = AN_OFF;
    nib_c    = 4'd0;
    blank_c  = 1'b0;

    // Scan is frozen while dark so the first load starts on the units digit
    if (estado_q != APAGADO) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // error_en outranks cargar and never latches the value
    if (bus.error_en) begin
      estado_d = ERROR;
    end else if (bus.cargar) begin
      if (valido_c) begin
        estado_d = BARRER;
        valor_d  = bus.numero;
      end else begin
        estado_d = ERROR;
      end
    end

    inv_d = (estado_d == ERROR);

    case (idx_q)
      2'd0: begin nib_c = valor_q[3:0];   blank_c = 1'b0;                   end
      2'd1: begin nib_c = valor_q[7:4];   blank_c = (valor_q[15:4]  == '0); end
      2'd2: begin nib_c = valor_q[11:8];  blank_c = (valor_q[15:8]  == '0); end
      default: begin nib_c = valor_q[15:12]; blank_c = (valor_q[15:12] == '0); end
    endcase

    case (estado_q)
      BARRER: begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank_c ? SEG_OFF : decode(nib_c);
      end
      ERROR: begin
        an_d = ~(4'b0001 << idx_q);
        case (idx_q)
          2'd3:    seg_d = 7'h06;
          2'd2:    seg_d = 7'h2F;
          2'd1:    seg_d = 7'h2F;
          default: seg_d = SEG_OFF;
        endcase
      end
      default: begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q <= APAGADO;
      valor_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      listo_q  <= 1'b0;
      inv_q    <= 1'b0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
    end else begin
      estado_q <= estado_d;
      valor_q  <= valor_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      listo_q  <= listo_d;
      inv_q    <= inv_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign bus.segmentos = seg_q;
  assign bus.anodos    = an_q;
  assign bus.listo     = listo_q;
  assign bus.invalido  = inv_q;

endmodule

// File: tb/tb_modulo_mostrar_numero.sv
// Directed bench for modulo_mostrar_numero with a cycle-level behavioural model.
module tb_modulo_mostrar_numero;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned CNT_W    = 16;

  logic clk;
  logic reset;

  modulo_mostrar_numero_if bus_if ();

  modulo_mostrar_numero #(
    .SCAN_DIV(SCAN_DIV),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 = dark, 1 = scanning a number, 2 = showing Err
  int          m_mode  = 0;
  logic [15:0] m_val   = '0;
  int          m_ticks = 0;
  logic [6:0]  e_seg   = 7'h7F;
  logic [3:0]  e_an    = 4'hF;
  logic        e_listo = 1'b0;
  logic        e_inv   = 1'b0;

  logic [6:0] dec_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [6:0] err_tab [4]  = '{7'h7F, 7'h2F, 7'h2F, 7'h06};
  logic [3:0] an_tab  [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};

  function automatic logic bcd_ok(input logic [15:0] v);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] sh;
      sh = v >> (4 * k);
      if (sh[3:0] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Advance the model by one clock edge, using the inputs in effect at that edge
  task automatic model_step();
    int          idx;
    logic [15:0] upper;
    if (!reset) begin
      e_seg = 7'h7F; e_an = 4'hF; e_listo = 1'b0; e_inv = 1'b0;
      m_mode = 0; m_val = '0; m_ticks = 0;
    end else begin
      idx   = (m_ticks / int'(SCAN_DIV)) % 4;
      upper = m_val >> (4 * idx);
      if (m_mode == 0) begin
        e_seg = 7'h7F; e_an = 4'hF;
      end else begin
        e_an = an_tab[idx];
        if (m_mode == 2)                     e_seg = err_tab[idx];
        else if (idx != 0 && upper == 16'd0) e_seg = 7'h7F;
        else                                 e_seg = dec_tab[int'(upper[3:0])];
      end
      e_listo = bus_if.cargar | bus_if.error_en;
      if (m_mode != 0) m_ticks = (m_ticks + 1) % (4 * int'(SCAN_DIV));
      if (bus_if.error_en) m_mode = 2;
      else if (bus_if.cargar) begin
        if (bcd_ok(bus_if.numero)) begin
          m_mode = 1; m_val = bus_if.numero;
        end else begin
          m_mode = 2;
        end
      end
      e_inv = (m_mode == 2);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: update model at the edge, compare all outputs at the falling edge
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_segmentos", 16'(bus_if.segmentos), 16'(e_seg));
    chk("model_anodos",    16'(bus_if.anodos),    16'(e_an));
    chk("model_listo",     16'(bus_if.listo),     16'(e_listo));
    chk("model_invalido",  16'(bus_if.invalido),  16'(e_inv));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    run(n);
    reset = 1'b1;
  endtask

  task automatic pulse(input logic [15:0] v, input logic err, input logic ld);
    bus_if.numero   = v;
    bus_if.cargar   = ld;
    bus_if.error_en = err;
    cyc();
    bus_if.cargar   = 1'b0;
    bus_if.error_en = 1'b0;
  endtask

  task automatic chk_disp(input string name, input logic [6:0] s, input logic [3:0] a);
    chk({name, "_seg"}, 16'(bus_if.segmentos), 16'(s));
    chk({name, "_an"},  16'(bus_if.anodos),    16'(a));
  endtask

  logic [6:0] seg1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

  initial begin
    reset           = 1'b0;
    bus_if.numero   = '0;
    bus_if.cargar   = 1'b0;
    bus_if.error_en = 1'b0;

    // Reset, then stay dark with no load
    run(3);
    chk_disp("reset", 7'h7F, 4'hF);
    chk("reset_listo", 16'(bus_if.listo), 16'd0);
    chk("reset_inv",   16'(bus_if.invalido), 16'd0);
    reset = 1'b1;
    run(6);
    chk_disp("dark", 7'h7F, 4'hF);

    // 1234: one listo pulse, then E/19 D/30 B/24 7/79 for 4 cycles each
    pulse(16'h1234, 1'b0, 1'b1);
    chk("listo_1234", 16'(bus_if.listo), 16'd1);
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (i == 0) chk("listo_1234_drop", 16'(bus_if.listo), 16'd0);
      chk_disp("scan_1234", seg1234[i / 4], an_tab[i / 4]);
    end

    // 0050: digits 2 and 3 blank but still strobed
    do_reset(1);
    pulse(16'h0050, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (i == 0)  chk_disp("z0050_d0", 7'h40, 4'hE);
      if (i == 4)  chk_disp("z0050_d1", 7'h12, 4'hD);
      if (i == 8)  chk_disp("z0050_d2", 7'h7F, 4'hB);
      if (i == 12) chk_disp("z0050_d3", 7'h7F, 4'h7);
    end

    // 0000: single 0 on the units digit
    do_reset(1);
    pulse(16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (i == 0) chk_disp("z0000_d0", 7'h40, 4'hE);
      if (i == 4) chk_disp("z0000_d1", 7'h7F, 4'hD);
    end

    // Interior zeros are shown
    pulse(16'h1005, 1'b0, 1'b1);
    run(17);

    // Invalid load from scan -> Err, then recover with 0009
    pulse(16'h12A4, 1'b0, 1'b1);
    chk("listo_12A4", 16'(bus_if.listo), 16'd1);
    chk("inv_12A4",   16'(bus_if.invalido), 16'd1);
    run(16);
    pulse(16'hF000, 1'b0, 1'b1);
    chk("inv_stays", 16'(bus_if.invalido), 16'd1);
    run(4);
    pulse(16'h0009, 1'b0, 1'b1);
    chk("inv_clear", 16'(bus_if.invalido), 16'd0);
    run(16);

    // error_en and cargar together: error wins, single listo pulse
    pulse(16'h0007, 1'b1, 1'b1);
    chk("both_listo", 16'(bus_if.listo), 16'd1);
    chk("both_inv",   16'(bus_if.invalido), 16'd1);
    cyc();
    chk("both_listo_drop", 16'(bus_if.listo), 16'd0);
    run(8);
    pulse(16'h0123, 1'b0, 1'b1);
    run(16);

    // error_en from the dark state
    do_reset(2);
    pulse(16'h0000, 1'b1, 1'b0);
    chk("err_dark_inv", 16'(bus_if.invalido), 16'd1);
    run(16);

    // Reset mid-scan at index 2, then a new load restarts at digit 0
    do_reset(1);
    pulse(16'h1234, 1'b0, 1'b1);
    run(9);
    chk("mid_idx2_an", 16'(bus_if.anodos), 16'hB);
    reset = 1'b0;
    cyc();
    chk_disp("mid_reset", 7'h7F, 4'hF);
    chk("mid_reset_listo", 16'(bus_if.listo), 16'd0);
    reset = 1'b1;
    pulse(16'h5678, 1'b0, 1'b1);
    cyc();
    chk_disp("restart_d0", 7'h00, 4'hE);
    run(16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
